spi_controller: RTL and testbench



---
 rtl/spi_pkg.sv | 30 +++
 rtl/spi_clk_div.sv | 31 +++
 rtl/spi_controller.sv | 119 +++++++++++
 tb/tb_spi_controller.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the register-write SPI link: frame layout,
// register map and controller state encoding.
package spi_pkg;

    localparam int FRAME_W  = 16;
    localparam int ADDR_W   = 7;
    localparam int DATA_W   = 8;

    localparam int RW_BIT   = 15;
    localparam int ADDR_MSB = 14;
    localparam int ADDR_LSB = 8;

    localparam logic RW_WRITE = 1'b1;

    localparam logic [ADDR_W-1:0] REG_OUT_7_0  = 7'h00;
    localparam logic [ADDR_W-1:0] REG_OUT_15_8 = 7'h01;
    localparam logic [ADDR_W-1:0] REG_PWM_7_0  = 7'h02;
    localparam logic [ADDR_W-1:0] REG_PWM_15_8 = 7'h03;
    localparam logic [ADDR_W-1:0] REG_PWM_DUTY = 7'h04;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT_HI,
        SHIFT_LO,
        HOLD,
        GAP
    } spi_state_t;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period timer for sclk: tick marks the last cycle of each
// CLK_DIV-cycle phase, after which the count restarts from zero.
module spi_clk_div #(
    parameter int CLK_DIV = 4
) (
    input  logic counter_clock,
    input  logic rstn,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int CW = $clog2(CLK_DIV) + 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] div_cnt;

    assign tick = enable && (div_cnt == LAST);

    // Every tick coincides with a state change, so wrapping here is the restart.
    always_ff @(posedge counter_clock) begin
        if (!rstn) begin
            div_cnt <= '0;
        end else if (clear || tick) begin
            div_cnt <= '0;
        end else if (enable) begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 initiator: shifts one {rw, addr, data} frame MSB first per
// accepted start, capturing cipo on every sclk rise.
//
// state    | meaning
// IDLE     | ncs high, waiting for start
// SETUP    | ncs low, sclk low, first bit set up on copi
// SHIFT_HI | sclk high, cipo captured on entry
// SHIFT_LO | sclk low, next bit presented on copi
// HOLD     | sclk low after last bit, ncs still low
// GAP      | ncs high, minimum deselect time before done
module spi_controller
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       counter_clock,
    input  logic       rstn,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    input  logic       cipo,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       ncs,
    output logic       sclk,
    output logic       copi
);

    localparam int SHIFT_W = FRAME_W - 1;
    localparam logic [3:0] LAST_BIT = 4'(FRAME_W - 1);

    spi_state_t          state;
    logic [SHIFT_W-1:0]  shift_reg;
    logic [3:0]          bit_cnt;
    logic [DATA_W-1:0]   rx;
    logic                tick;

    spi_clk_div #(
        .CLK_DIV(CLK_DIV)
    ) u_clk_div (
        .counter_clock(counter_clock),
        .rstn         (rstn),
        .clear        (state == IDLE),
        .enable       (state != IDLE),
        .tick         (tick)
    );

    // The rw bit goes straight to copi, so shift_reg only carries addr and data.
    always_ff @(posedge counter_clock) begin
        if (!rstn) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            rx        <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rdata     <= '0;
            ncs       <= 1'b1;
            sclk      <= 1'b0;
            copi      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shift_reg <= {addr, wdata};
                        bit_cnt   <= '0;
                        ncs       <= 1'b0;
                        sclk      <= 1'b0;
                        copi      <= rw;
                        busy      <= 1'b1;
                        state     <= SETUP;
                    end
                end
                SETUP, SHIFT_LO: begin
                    if (tick) begin
                        sclk  <= 1'b1;
                        rx    <= {rx[DATA_W-2:0], cipo};
                        state <= SHIFT_HI;
                    end
                end
                SHIFT_HI: begin
                    if (tick) begin
                        sclk <= 1'b0;
                        if (bit_cnt == LAST_BIT) begin
                            state <= HOLD;
                        end else begin
                            copi      <= shift_reg[SHIFT_W-1];
                            shift_reg <= {shift_reg[SHIFT_W-2:0], 1'b0};
                            bit_cnt   <= bit_cnt + 1'b1;
                            state     <= SHIFT_LO;
                        end
                    end
                end
                HOLD: begin
                    if (tick) begin
                        ncs   <= 1'b1;
                        copi  <= 1'b0;
                        state <= GAP;
                    end
                end
                GAP: begin
                    if (tick) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        rdata <= rx;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_controller.sv
// Directed bench for spi_controller: frame content, timing, back-to-back,
// mid-frame reset, start-while-busy, read capture and CLK_DIV=1.
module tb_spi_controller;

    logic       counter_clock = 1'b0;
    logic       rstn = 1'b0;

    logic       start = 1'b0, rw = 1'b0, cipo;
    logic [6:0] addr = '0;
    logic [7:0] wdata = '0;
    logic       busy, done, ncs, sclk, copi;
    logic [7:0] rdata;

    logic       start1 = 1'b0, rw1 = 1'b0;
    logic [6:0] addr1 = '0;
    logic [7:0] wdata1 = '0;
    logic       busy1, done1, ncs1, sclk1, copi1;
    logic [7:0] rdata1;

    int checks = 0;
    int failures = 0;

    always #5 counter_clock = ~counter_clock;

    spi_controller #(.CLK_DIV(4)) u_dut (
        .counter_clock(counter_clock), .rstn(rstn), .start(start), .rw(rw),
        .addr(addr), .wdata(wdata), .cipo(cipo), .busy(busy), .done(done),
        .rdata(rdata), .ncs(ncs), .sclk(sclk), .copi(copi)
    );

    spi_controller #(.CLK_DIV(1)) u_dut1 (
        .counter_clock(counter_clock), .rstn(rstn), .start(start1), .rw(rw1),
        .addr(addr1), .wdata(wdata1), .cipo(1'b0), .busy(busy1), .done(done1),
        .rdata(rdata1), .ncs(ncs1), .sclk(sclk1), .copi(copi1)
    );

    // Link monitor and loopback peripheral for the CLK_DIV=4 instance.
    logic        prev_sclk = 1'b0, prev_ncs = 1'b1;
    int          low_cnt = 0, hi_cnt = 0, low_len = 0, hi_len = 0;
    int          rises = 0, frame_rises = 0, frames = 0, done_cnt = 0;
    logic [15:0] cap = '0, frame_bits = '0;
    logic [7:0]  regs [0:127] = '{default: 8'h00};
    logic [15:0] cipo_pat = '0;
    logic [3:0]  cidx;

    assign cidx = 4'(15 - rises);
    assign cipo = (rises < 16) ? cipo_pat[cidx] : 1'b0;

    always @(negedge counter_clock) begin
        prev_sclk <= sclk;
        prev_ncs  <= ncs;
        if (ncs === 1'b0) begin
            if (prev_ncs) begin
                low_cnt <= 1;
                rises   <= 0;
                hi_len  <= hi_cnt;
            end else begin
                low_cnt <= low_cnt + 1;
            end
        end else begin
            if (!prev_ncs) begin
                hi_cnt      <= 1;
                low_len     <= low_cnt;
                frame_bits  <= cap;
                frame_rises <= rises;
                frames      <= frames + 1;
                if (rises == 16 && cap[15])
                    regs[cap[14:8]] <= cap[7:0];
            end else begin
                hi_cnt <= hi_cnt + 1;
            end
        end
        if (sclk === 1'b1 && !prev_sclk) begin
            rises <= rises + 1;
            cap   <= {cap[14:0], copi};
        end
        if (done === 1'b1)
            done_cnt <= done_cnt + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic r, input logic [6:0] a, input logic [7:0] d);
        @(negedge counter_clock);
        rw = r; addr = a; wdata = d; start = 1'b1;
        @(posedge counter_clock);
        #1 start = 1'b0;
    endtask

    // Cycles from the start-sampling edge to the first done; 0 on timeout.
    task automatic wait_done(output int lat);
        int n;
        lat = 0;
        n = 0;
        while (lat == 0 && n < 400) begin
            @(negedge counter_clock);
            n++;
            if (done) lat = n;
        end
    endtask

    initial begin
        int lat, lat2, d0, f0, n, r1, l1, lat1;
        logic [15:0] f1;
        logic ps;

        repeat (3) @(posedge counter_clock);
        @(negedge counter_clock);
        check_val("rst_ncs", ncs, 1);
        check_val("rst_sclk", sclk, 0);
        check_val("rst_copi", copi, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_rdata", rdata, 0);
        check_val("rst1_ncs_busy", {ncs1, sclk1, busy1, done1}, 4'b1000);
        rstn = 1'b1;

        // Write 0xA5 to out_7_0
        send(1'b1, 7'h00, 8'hA5);
        @(negedge counter_clock);
        check_val("t1_accept", {ncs, copi, busy, sclk}, 4'b0110);
        wait_done(lat);
        check_val("t1_done_lat", lat + 1, 137);
        @(negedge counter_clock);
        check_val("t1_done_pulse", done, 0);
        @(negedge counter_clock);
        check_val("t1_frame", frame_bits, 16'h80A5);
        check_val("t1_rises", frame_rises, 16);
        check_val("t1_ncs_low", low_len, 132);
        check_val("t1_reg", regs[0], 8'hA5);
        check_val("t1_rdata", rdata, 0);

        // Back-to-back with start held high
        @(negedge counter_clock);
        rw = 1'b1; addr = 7'h02; wdata = 8'h55; start = 1'b1;
        @(posedge counter_clock);
        #1 addr = 7'h04; wdata = 8'h80;
        wait_done(lat);
        @(posedge counter_clock);
        #1 start = 1'b0;
        wait_done(lat2);
        check_val("t2_lat_a", lat, 137);
        check_val("t2_lat_b", lat2, 137);
        check_val("t2_gap", hi_len, 5);
        repeat (2) @(negedge counter_clock);
        check_val("t2_pwm", regs[2], 8'h55);
        check_val("t2_duty", regs[4], 8'h80);

        // Reset after the 5th sclk rise
        d0 = done_cnt;
        send(1'b1, 7'h01, 8'h77);
        n = 0;
        while (rises != 5 && n < 200) begin
            @(negedge counter_clock);
            n++;
        end
        check_val("t3_reach5", rises, 5);
        rstn = 1'b0;
        @(posedge counter_clock);
        @(negedge counter_clock);
        check_val("t3_idle", {ncs, sclk, busy, done}, 4'b1000);
        check_val("t3_rdata", rdata, 0);
        rstn = 1'b1;
        repeat (200) @(negedge counter_clock);
        check_val("t3_no_done", done_cnt - d0, 0);
        check_val("t3_no_write", regs[1], 8'h00);
        send(1'b1, 7'h01, 8'h3C);
        wait_done(lat);
        check_val("t3_lat", lat, 137);
        repeat (2) @(negedge counter_clock);
        check_val("t3_reg", regs[1], 8'h3C);

        // start while busy; nonzero cipo on a write updates rdata
        cipo_pat = 16'h00C3;
        d0 = done_cnt;
        f0 = frames;
        send(1'b1, 7'h03, 8'h12);
        for (int i = 1; i <= 300; i++) begin
            @(negedge counter_clock);
            if (i == 40) start = 1'b1;
            if (i == 41) start = 1'b0;
        end
        check_val("t4_one_done", done_cnt - d0, 1);
        check_val("t4_one_frame", frames - f0, 1);
        check_val("t4_idle", {ncs, busy}, 2'b10);
        check_val("t4_frame", frame_bits, 16'h8312);
        check_val("t4_rdata", rdata, 8'hC3);

        // Read of pwm_duty
        cipo_pat = 16'h003C;
        send(1'b0, 7'h04, 8'h00);
        wait_done(lat);
        check_val("t5_rdata", rdata, 8'h3C);
        check_val("t5_lat", lat, 137);
        repeat (2) @(negedge counter_clock);
        check_val("t5_frame", frame_bits, 16'h0400);
        check_val("t5_no_write", regs[4], 8'h80);

        // CLK_DIV=1 instance
        @(negedge counter_clock);
        rw1 = 1'b1; addr1 = 7'h2A; wdata1 = 8'h96; start1 = 1'b1;
        @(posedge counter_clock);
        #1 start1 = 1'b0;
        lat1 = 0; r1 = 0; l1 = 0; f1 = '0; ps = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge counter_clock);
            if (!ncs1) l1++;
            if (sclk1 && !ps) begin
                r1++;
                f1 = {f1[14:0], copi1};
            end
            ps = sclk1;
            if (done1 && lat1 == 0) lat1 = i;
        end
        check_val("t6_lat", lat1, 35);
        check_val("t6_rises", r1, 16);
        check_val("t6_ncs_low", l1, 33);
        check_val("t6_frame", f1, 16'hAA96);
        check_val("t6_idle", {ncs1, busy1, sclk1}, 3'b100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
